addr_gen_seq: RTL and testbench
===============================

# addr_gen_seq

Parametrised, restartable address sequencer for the LSTM forward and BPTT datapath. It replaces the fixed per-purpose x, aifo, bias and weight generators with one block that walks timestep × burst × element loops with an inter-burst pipeline pause. It optionally walks timesteps in reverse for backpropagation. One instance exists per memory port, driven by the fsm through `start`/`en`, and it reports completion back to the fsm.

## Interface
- `ADDR_WIDTH`, 12: output address width.
- `BURST_LEN`, 53: consecutive addresses per burst (e.g. NUM_INPUT); ≥1.
- `NUM_BURST`, 53: bursts per timestep (e.g. NUM_CELL); ≥1.
- `TIMESTEP`, 7: timesteps per sequence; ≥1.
- `PAUSE_LEN`, 4: idle cycles after every burst (MAC/activation latency); 0 allowed.
- `BURST_STRIDE`, 53: address offset between bursts. 0 means every burst rereads the same vector.
- `FRAME_STRIDE`, 53: address offset between timesteps.
- `BASE`, 0: address of element 0, burst 0, timestep 0.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sequence. Sampled only in IDLE with `en`=1.
- `en`  in  1  advance enable. When 0, all state and outputs are frozen.
- `rev`  in  1  reverse timestep order. Latched on an accepted `start`.
- `o_addr`  out  ADDR_WIDTH  current address.
- `o_valid`  out  1  `o_addr` is a real access (RUN state).
- `o_burst_last`  out  1  last element of a burst.
- `o_step_last`  out  1  last element of the last burst of a timestep.
- `o_busy`  out  1  state ≠ IDLE.
- `o_done`  out  1  one-cycle pulse after the final pause.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - `start`&`en` latches `rev`, clears the counters k (element), b (burst) and t (timestep), and moves to RUN.
  - `start` outside IDLE is ignored.
- RUN:
  - o_addr = BASE + t'·FRAME_STRIDE + b·BURST_STRIDE + k, modulo 2^ADDR_WIDTH.
  - t' = t when forward, TIMESTEP-1-t when reversed.
  - k increments each cycle.
  - At k=BURST_LEN-1, go to PAUSE if PAUSE_LEN>0. Otherwise go directly to the next burst, or to DONE after the final burst.
- PAUSE:
  - Lasts PAUSE_LEN cycles with `o_valid`=0; `o_addr` holds its last value.
  - Then k←0 and b increments. On b wrap, b←0 and t increments.
  - After the last burst of the last timestep, go to DONE.
- DONE: `o_done`=1 for one cycle, then IDLE. A `start` in this cycle is ignored.
- Address arithmetic:
  - Computed internally at ADDR_WIDTH+8 bits, then truncated.
  - Wrap-around is silent and legal.
  - Offsets are built incrementally (add strides); there are no multipliers.
- Flags are registered with `o_addr`:
  - `o_burst_last` = RUN & k=BURST_LEN-1.
  - `o_step_last` = `o_burst_last` & b=NUM_BURST-1.
- `rst` low at any time, including mid-sequence, forces IDLE immediately and asynchronously. All outputs go to 0 and the counters clear.

## Timing
- All outputs are registered. Reset values: `o_addr`=0, `o_valid`=0, `o_burst_last`=0, `o_step_last`=0, `o_busy`=0, `o_done`=0.
- Accepted `start` at edge 0: the first valid address appears after edge 0 (latency 1). `o_busy` rises in the same cycle.
- With N = TIMESTEP·NUM_BURST, `o_done` is high in cycle N·(BURST_LEN+PAUSE_LEN)+1 after the start edge, counting only `en`=1 cycles.
- `en`=0 stalls exactly one cycle per low cycle. Outputs are held, including `o_valid` and `o_done`, so a stalled `o_done` persists until the next `en`=1 edge.
- Back-to-back sequences: the earliest restart is the `start` accepted in the IDLE cycle following DONE.

## Configuration
- `ADDR_GEN_REV_EN` defined: `rev` is latched, and reverse order (t' = TIMESTEP-1-t) is supported.
- Undefined: `rev` is ignored; the port remains present but unconnected internally. Order is always forward, and the reverse subtractor is not synthesised.

## Test plan
Parameters for all scenarios unless stated: BURST_LEN=3, NUM_BURST=2, TIMESTEP=2, PAUSE_LEN=1, BURST_STRIDE=3, FRAME_STRIDE=6, BASE=0, ADDR_WIDTH=12.

- Forward: `start`, `rev`=0 → valid addrs 0,1,2 | 3,4,5 | 6,7,8 | 9,10,11, each burst followed by one invalid cycle. `o_burst_last` on 2,5,8,11; `o_step_last` on 5,11; `o_done` in cycle 17.
- Reverse (macro defined): `start`, `rev`=1 → 6,7,8 | 9,10,11 | 0,1,2 | 3,4,5; `o_done` in cycle 17. With the macro undefined, the same stimulus yields the forward sequence.
- BURST_STRIDE=0, PAUSE_LEN=0 → 0,1,2,0,1,2,6,7,8,6,7,8 contiguous with no gaps; `o_done` in cycle 13.
- ADDR_WIDTH=4, BASE=14 → first burst 14,15,0, then continues with wrapped addresses 1,2,3 and no error.
- `en` held low 3 cycles right after address 4 → 4 is repeated for 3 cycles with `o_valid` held. The sequence resumes at 5, and `o_done` moves to cycle 20.
- `rst` pulsed low at address 7 → all outputs 0 asynchronously. After release, a new `start` restarts from address 0. A `start` during RUN has no effect.

Source files
------------

// File: rtl/addr_gen_seq_if.sv
// Control/status bundle between the sequencing fsm (master) and one addr_gen_seq instance (slave).
// The fsm drives start/en/rev; the generator returns the address stream and status flags.
interface addr_gen_seq_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic                  en;
    logic                  rev;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic                  o_valid;
    logic                  o_burst_last;
    logic                  o_step_last;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        output start, en, rev,
        input  o_addr, o_valid, o_burst_last, o_step_last, o_busy, o_done
    );

    modport slave (
        input  start, en, rev,
        output o_addr, o_valid, o_burst_last, o_step_last, o_busy, o_done
    );
endinterface

// File: rtl/addr_gen_seq.sv
// Restartable timestep x burst x element address sequencer with an inter-burst pause.
// Define ADDR_GEN_REV_EN to support reverse timestep order (rev); otherwise order is always forward.
module addr_gen_seq #(
    parameter int ADDR_WIDTH   = 12,
    parameter int BURST_LEN    = 53,
    parameter int NUM_BURST    = 53,
    parameter int TIMESTEP     = 7,
    parameter int PAUSE_LEN    = 4,
    parameter int BURST_STRIDE = 53,
    parameter int FRAME_STRIDE = 53,
    parameter int BASE         = 0
) (
    input  logic          clk,
    input  logic          rst,
    addr_gen_seq_if.slave bus
);
    localparam int IW = ADDR_WIDTH + 8;
    localparam int KW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BW = (NUM_BURST > 1) ? $clog2(NUM_BURST) : 1;
    localparam int TW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
    localparam int PW = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(BURST_LEN - 1);
    localparam logic [BW-1:0] B_LAST = BW'(NUM_BURST - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMESTEP - 1);
    localparam logic [PW-1:0] P_LAST = PW'((PAUSE_LEN > 0) ? PAUSE_LEN - 1 : 0);
    localparam logic [IW-1:0] BASE_I = IW'(BASE);
    localparam logic [IW-1:0] BSTR_I = IW'(BURST_STRIDE);
    localparam logic [IW-1:0] FSTR_I = IW'(FRAME_STRIDE);
`ifdef ADDR_GEN_REV_EN
    localparam logic [IW-1:0] REV_START = IW'((TIMESTEP - 1) * FRAME_STRIDE);
`endif

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t                state_q, state_n;
    logic [KW-1:0]         k_q, k_n;
    logic [BW-1:0]         b_q, b_n;
    logic [TW-1:0]         t_q, t_n;
    logic [PW-1:0]         p_q, p_n;
    logic [IW-1:0]         frame_q, frame_n;
    logic [IW-1:0]         burst_q, burst_n;
    logic [IW-1:0]         frame_step;
    logic                  last_burst;
    logic                  advance;
`ifdef ADDR_GEN_REV_EN
    logic                  rev_q, rev_n;
`endif

    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic                  valid_q, burst_last_q, step_last_q, busy_q, done_q;
    logic                  burst_last_n, step_last_n;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_n    = state_q;
        k_n        = k_q;
        b_n        = b_q;
        t_n        = t_q;
        p_n        = p_q;
        frame_n    = frame_q;
        burst_n    = burst_q;
        advance    = 1'b0;
        last_burst = (b_q == B_LAST) && (t_q == T_LAST);
`ifdef ADDR_GEN_REV_EN
        rev_n      = rev_q;
        frame_step = rev_q ? (frame_q - FSTR_I) : (frame_q + FSTR_I);
`else
        frame_step = frame_q + FSTR_I;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    k_n     = '0;
                    b_n     = '0;
                    t_n     = '0;
                    p_n     = '0;
                    burst_n = '0;
`ifdef ADDR_GEN_REV_EN
                    rev_n   = bus.rev;
                    frame_n = bus.rev ? REV_START : '0;
`else
                    frame_n = '0;
`endif
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    if (PAUSE_LEN > 0) begin
                        state_n = PAUSE;
                        p_n     = '0;
                    end else if (last_burst) begin
                        state_n = DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    k_n = k_q + KW'(1);
                end
            end
            PAUSE: begin
                if (p_q == P_LAST) begin
                    if (last_burst) state_n = DONE;
                    else            advance = 1'b1;
                end else begin
                    p_n = p_q + PW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Step to the next burst; offsets are accumulated so no multiplier is needed.
        if (advance) begin
            state_n = RUN;
            k_n     = '0;
            if (b_q == B_LAST) begin
                b_n     = '0;
                burst_n = '0;
                t_n     = t_q + TW'(1);
                frame_n = frame_step;
            end else begin
                b_n     = b_q + BW'(1);
                burst_n = burst_q + BSTR_I;
            end
        end

        addr_n       = (state_n == RUN) ? ADDR_WIDTH'(BASE_I + frame_n + burst_n + IW'(k_n)) : addr_q;
        burst_last_n = (state_n == RUN) && (k_n == K_LAST);
        step_last_n  = burst_last_n && (b_n == B_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            b_q          <= '0;
            t_q          <= '0;
            p_q          <= '0;
            frame_q      <= '0;
            burst_q      <= '0;
`ifdef ADDR_GEN_REV_EN
            rev_q        <= 1'b0;
`endif
            addr_q       <= '0;
            valid_q      <= 1'b0;
            burst_last_q <= 1'b0;
            step_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (bus.en) begin
            state_q      <= state_n;
            k_q          <= k_n;
            b_q          <= b_n;
            t_q          <= t_n;
            p_q          <= p_n;
            frame_q      <= frame_n;
            burst_q      <= burst_n;
`ifdef ADDR_GEN_REV_EN
            rev_q        <= rev_n;
`endif
            addr_q       <= addr_n;
            valid_q      <= (state_n == RUN);
            burst_last_q <= burst_last_n;
            step_last_q  <= step_last_n;
            busy_q       <= (state_n != IDLE);
            done_q       <= (state_n == DONE);
        end
    end

    assign bus.o_addr       = addr_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_burst_last = burst_last_q;
    assign bus.o_step_last  = step_last_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
endmodule

// File: tb/tb_addr_gen_seq.sv
// Directed bench for addr_gen_seq: three instances cover pause/no-pause/address-wrap parameter sets.
// Flags are packed {busy, done, valid, burst_last, step_last}: 20 run, 22 burst end, 23 step end, 16 pause, 24 done.
module tb_addr_gen_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    addr_gen_seq_if #(.ADDR_WIDTH(12)) if_main ();
    addr_gen_seq_if #(.ADDR_WIDTH(12)) if_np ();
    addr_gen_seq_if #(.ADDR_WIDTH(4))  if_wrap ();

    addr_gen_seq #(
        .ADDR_WIDTH(12), .BURST_LEN(3), .NUM_BURST(2), .TIMESTEP(2), .PAUSE_LEN(1),
        .BURST_STRIDE(3), .FRAME_STRIDE(6), .BASE(0)
    ) u_main (.clk(clk), .rst(rst), .bus(if_main.slave));

    addr_gen_seq #(
        .ADDR_WIDTH(12), .BURST_LEN(3), .NUM_BURST(2), .TIMESTEP(2), .PAUSE_LEN(0),
        .BURST_STRIDE(0), .FRAME_STRIDE(6), .BASE(0)
    ) u_np (.clk(clk), .rst(rst), .bus(if_np.slave));

    addr_gen_seq #(
        .ADDR_WIDTH(4), .BURST_LEN(3), .NUM_BURST(2), .TIMESTEP(2), .PAUSE_LEN(1),
        .BURST_STRIDE(3), .FRAME_STRIDE(6), .BASE(14)
    ) u_wrap (.clk(clk), .rst(rst), .bus(if_wrap.slave));

    task automatic drive(input int sel, input logic s, input logic e, input logic r);
        case (sel)
            0:       begin if_main.start = s; if_main.en = e; if_main.rev = r; end
            1:       begin if_np.start   = s; if_np.en   = e; if_np.rev   = r; end
            default: begin if_wrap.start = s; if_wrap.en = e; if_wrap.rev = r; end
        endcase
    endtask

    task automatic sample(input int sel, output logic [15:0] a, output logic [4:0] f);
        case (sel)
            0: begin
                a = 16'(if_main.o_addr);
                f = {if_main.o_busy, if_main.o_done, if_main.o_valid, if_main.o_burst_last, if_main.o_step_last};
            end
            1: begin
                a = 16'(if_np.o_addr);
                f = {if_np.o_busy, if_np.o_done, if_np.o_valid, if_np.o_burst_last, if_np.o_step_last};
            end
            default: begin
                a = 16'(if_wrap.o_addr);
                f = {if_wrap.o_busy, if_wrap.o_done, if_wrap.o_valid, if_wrap.o_burst_last, if_wrap.o_step_last};
            end
        endcase
    endtask

    task automatic test_reset();
        logic [15:0] a;
        logic [4:0]  f;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sample(s, a, f);
            vectors++;
            if (a !== 16'd0 || f !== 5'd0) begin
                $display("FAIL reset dut%0d: addr=%0d flags=%0d, expected addr=0 flags=0", s, a, f);
                miscompares++;
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        int ea[$] = '{0,1,2,2,3,4,5,5,6,7,8,8,9,10,11,11,11,11};
        int ef[$] = '{20,20,22,16,20,20,23,16,20,20,22,16,20,20,23,16,24,0};
        logic [15:0] a;
        logic [4:0]  f;
        drive(0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < ea.size(); i++) begin
            sample(0, a, f);
            vectors++;
            if (a !== 16'(ea[i]) || f !== 5'(ef[i])) begin
                $display("FAIL forward cycle %0d: addr=%0d flags=%0d, expected addr=%0d flags=%0d", i + 1, a, f, ea[i], ef[i]);
                miscompares++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reverse();
`ifdef ADDR_GEN_REV_EN
        int ea[$] = '{6,7,8,8,9,10,11,11,0,1,2,2,3,4,5,5,5,5};
`else
        int ea[$] = '{0,1,2,2,3,4,5,5,6,7,8,8,9,10,11,11,11,11};
`endif
        int ef[$] = '{20,20,22,16,20,20,23,16,20,20,22,16,20,20,23,16,24,0};
        logic [15:0] a;
        logic [4:0]  f;
        drive(0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < ea.size(); i++) begin
            sample(0, a, f);
            vectors++;
            if (a !== 16'(ea[i]) || f !== 5'(ef[i])) begin
                $display("FAIL reverse cycle %0d: addr=%0d flags=%0d, expected addr=%0d flags=%0d", i + 1, a, f, ea[i], ef[i]);
                miscompares++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_no_pause();
        int ea[$] = '{0,1,2,0,1,2,6,7,8,6,7,8,8,8};
        int ef[$] = '{20,20,22,20,20,23,20,20,22,20,20,23,24,0};
        logic [15:0] a;
        logic [4:0]  f;
        drive(1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < ea.size(); i++) begin
            sample(1, a, f);
            vectors++;
            if (a !== 16'(ea[i]) || f !== 5'(ef[i])) begin
                $display("FAIL no_pause cycle %0d: addr=%0d flags=%0d, expected addr=%0d flags=%0d", i + 1, a, f, ea[i], ef[i]);
                miscompares++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        int ea[$] = '{14,15,0,0,1,2,3,3,4,5,6,6,7,8,9,9,9,9};
        int ef[$] = '{20,20,22,16,20,20,23,16,20,20,22,16,20,20,23,16,24,0};
        logic [15:0] a;
        logic [4:0]  f;
        drive(2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < ea.size(); i++) begin
            sample(2, a, f);
            vectors++;
            if (a !== 16'(ea[i]) || f !== 5'(ef[i])) begin
                $display("FAIL wrap cycle %0d: addr=%0d flags=%0d, expected addr=%0d flags=%0d", i + 1, a, f, ea[i], ef[i]);
                miscompares++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int ea[$] = '{0,1,2,2,3,4,4,4,4,5,5,6,7,8,8,9,10,11,11,11,11};
        int ef[$] = '{20,20,22,16,20,20,20,20,20,23,16,20,20,22,16,20,20,23,16,24,0};
        logic [15:0] a;
        logic [4:0]  f;
        drive(0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < ea.size(); i++) begin
            sample(0, a, f);
            vectors++;
            if (a !== 16'(ea[i]) || f !== 5'(ef[i])) begin
                $display("FAIL stall cycle %0d: addr=%0d flags=%0d, expected addr=%0d flags=%0d", i + 1, a, f, ea[i], ef[i]);
                miscompares++;
            end
            if (i + 1 == 6) drive(0, 1'b0, 1'b0, 1'b0);
            if (i + 1 == 9) drive(0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [4:0]  f;
        int          done_at;
        drive(0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c < 17; c++) @(negedge clk);
        sample(0, a, f);
        vectors++;
        if (f !== 5'd24) begin
            $display("FAIL b2b done cycle 17: flags=%0d, expected flags=24", f);
            miscompares++;
        end
        drive(0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        sample(0, a, f);
        vectors++;
        if (f !== 5'd0 || a !== 16'd11) begin
            $display("FAIL b2b start_in_done: addr=%0d flags=%0d, expected addr=11 flags=0", a, f);
            miscompares++;
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0);
        sample(0, a, f);
        vectors++;
        if (a !== 16'd0 || f !== 5'd20) begin
            $display("FAIL b2b restart: addr=%0d flags=%0d, expected addr=0 flags=20", a, f);
            miscompares++;
        end
        done_at = 0;
        for (int n = 2; n <= 30; n++) begin
            @(negedge clk);
            sample(0, a, f);
            if (f[3]) begin
                done_at = n;
                break;
            end
        end
        vectors++;
        if (done_at != 17) begin
            $display("FAIL b2b second done: cycle=%0d, expected cycle=17 (0 means timeout)", done_at);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int ea[$] = '{0,1,2,2,3,4,5,5,6,7};
        int ef[$] = '{20,20,22,16,20,20,23,16,20,20};
        logic [15:0] a;
        logic [4:0]  f;
        int          done_at;
        drive(0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < ea.size(); i++) begin
            sample(0, a, f);
            vectors++;
            if (a !== 16'(ea[i]) || f !== 5'(ef[i])) begin
                $display("FAIL run_start cycle %0d: addr=%0d flags=%0d, expected addr=%0d flags=%0d", i + 1, a, f, ea[i], ef[i]);
                miscompares++;
            end
            drive(0, (i == 0), 1'b1, 1'b0);
            if (i + 1 < ea.size()) @(negedge clk);
        end
        #2 rst = 1'b0;
        #1 sample(0, a, f);
        vectors++;
        if (a !== 16'd0 || f !== 5'd0) begin
            $display("FAIL async_reset: addr=%0d flags=%0d, expected addr=0 flags=0", a, f);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sample(0, a, f);
            vectors++;
            if (a !== 16'(ea[i]) || f !== 5'(ef[i])) begin
                $display("FAIL restart cycle %0d: addr=%0d flags=%0d, expected addr=%0d flags=%0d", i + 1, a, f, ea[i], ef[i]);
                miscompares++;
            end
            @(negedge clk);
        end
        done_at = 0;
        for (int n = 4; n <= 30; n++) begin
            sample(0, a, f);
            if (f[3]) begin
                done_at = n;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (done_at != 17) begin
            $display("FAIL restart done: cycle=%0d, expected cycle=17 (0 means timeout)", done_at);
            miscompares++;
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_no_pause();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
